// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// Latency: none, wires only.
// Backpressure: mem_ready from the memory side stalls the FSM in memory states.
interface control_fsm_if;
  // Instruction fields and status from the datapath
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  // Control back to the datapath
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  // The FSM side
  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, state
  );

  // The datapath side
  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle RISC-V style control FSM (lw/sw/R/I-ALU/beq/jal/lui, trap on anything else).
// Latency: lw 5, sw/R/I/lui/jal 4, beq 3 cycles when memory is ready.
// Backpressure: mem_ready=0 holds FETCH, MEMREAD and MEMWRITE one extra cycle each.
module control_fsm (
  input  logic          clk,
  input  logic          rst_n,
  control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t     state_q, state_d;
  logic [2:0] alu_fn;
  logic       pc_write, ir_write, reg_write, mem_write;

  // State register; reset lands in FETCH regardless of where we were
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // ALU function from funct3; subtract only for register-register with funct7b5
  always_comb begin
    alu_fn = 3'b000;
    case (bus.funct3)
      3'b000:  alu_fn = (bus.op == OP_R && bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_fn = 3'b101;
      3'b110:  alu_fn = 3'b011;
      3'b111:  alu_fn = 3'b010;
      default: alu_fn = 3'b000;
    endcase
  end

  // Immediate format depends only on the opcode, so it is valid in every state
  always_comb begin
    bus.ImmSrc = 3'b000;
    case (bus.op)
      OP_SW:   bus.ImmSrc = 3'b001;
      OP_BEQ:  bus.ImmSrc = 3'b010;
      OP_LUI:  bus.ImmSrc = 3'b011;
      OP_JAL:  bus.ImmSrc = 3'b100;
      default: bus.ImmSrc = 3'b000;
    endcase
  end

  // Next state and per-state control outputs
  always_comb begin
    state_d        = state_q;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    reg_write      = 1'b0;
    mem_write      = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 3'b000;
    bus.illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        ir_write      = bus.mem_ready;
        pc_write      = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          OP_LUI:       state_d = LUI;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_write     = 1'b1;
        state_d       = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        mem_write  = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_fn;
        state_d        = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_fn;
        state_d        = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = 3'b001;
        pc_write       = bus.zero;
        state_d        = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pc_write    = 1'b1;
        state_d     = ALUWB;
      end
      LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        state_d     = ALUWB;
      end
      TRAP: begin
        bus.illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Mask enables while reset is asserted; FETCH's Mealy outputs would otherwise follow mem_ready
  always_comb begin
    bus.PCWrite  = pc_write  & rst_n;
    bus.IRWrite  = ir_write  & rst_n;
    bus.RegWrite = reg_write & rst_n;
    bus.MemWrite = mem_write & rst_n;
    bus.state    = state_q;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have inputs: op in 7 (IR[6:0]); funct3 in 3 (IR[14:12]); funct7b5 in 1 (IR[30]); zero in 1 (ALU zero flag); mem_ready in 1 (memory access completes this cycle).
REQ-003 SHALL have write-enable outputs: PCWrite out 1; IRWrite out 1; RegWrite out 1; MemWrite out 1.
REQ-004 SHALL have select outputs: AdrSrc out 1 (0 PC, 1 Result); ALUSrcA out 2 (00 PC, 01 OldPC, 10 RD1, 11 zero); ALUSrcB out 2 (00 RD2, 01 ImmExt, 10 constant 4).
REQ-005 SHALL have outputs: ResultSrc out 2 (00 ALUOut, 01 Data, 10 ALUResult); ImmSrc out 3 (I 000, S 001, B 010, U 011, J 100); ALUControl out 3 (000 add, 001 sub, 010 and, 011 or, 101 slt); illegal out 1; state out 4 (debug).

Function
REQ-006 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP. Only PCWrite and IRWrite are Mealy.
REQ-007 SHALL decode opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111.
REQ-008 SHALL drive ImmSrc combinationally from op in every state: lw/I-ALU 000, sw 001, beq 010, lui 011, jal 100, any other op 000.
REQ-009 SHALL drive 0 on every enable not listed for the current state; unlisted selects are don't-care.
REQ-010 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10, IRWrite=PCWrite=mem_ready. It SHALL stay in FETCH while mem_ready=0 and move to DECODE when mem_ready=1.
REQ-011 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by op: lw/sw MEMADR; R EXECR; I-ALU EXECI; beq BEQ; jal JAL; lui LUI; other TRAP.
REQ-012 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add. Next state: MEMREAD for lw, MEMWRITE for sw.
REQ-013 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00. It SHALL hold until mem_ready=1, then go to MEMWB.
REQ-014 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-015 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 on every cycle in the state. It SHALL leave for FETCH on the cycle mem_ready=1.
REQ-016 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, function decode, then go to ALUWB.
REQ-017 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, function decode, then go to ALUWB.
REQ-018 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-019 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero, then go to FETCH.
REQ-020 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-021 LUI SHALL drive ALUSrcA=11, ALUSrcB=01, add, then go to ALUWB.
REQ-022 TRAP SHALL drive illegal=1 with all enables 0, and SHALL stay in TRAP until reset.
REQ-023 Function decode SHALL map funct3 as follows:
- 000: sub only when op=R and funct7b5=1, otherwise add.
- 010: slt.
- 110: or.
- 111: and.
- any other value: add.
REQ-024 Latency in cycles with mem_ready=1: lw 5; sw 4; R, I-ALU and lui 4; beq 3; jal 4. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
REQ-025 state SHALL read 0 for FETCH and then count up in REQ-006 order (TRAP=12).

Reset
REQ-026 rst_n=0 SHALL asynchronously force FETCH, illegal=0 and all write enables 0, including mid-MEMWRITE and in TRAP.
REQ-027 After rst_n rises, the first clock edge SHALL evaluate FETCH normally.

Verification
REQ-028 lw, mem_ready=1: state sequence 0,1,2,3,4,0; RegWrite=1 only in MEMWB; ImmSrc=000.
REQ-029 sw, mem_ready=0 for 3 MEMWRITE cycles then 1: MemWrite=1 for exactly 4 cycles; RegWrite never 1; ImmSrc=001.
REQ-030 beq with zero=1, then with zero=0: PCWrite=1 for one BEQ cycle only in the zero=1 case; ALUControl=001; ImmSrc=010.
REQ-031 Function decode:
- R with funct3=000, funct7b5=1: ALUControl=001 in EXECR.
- I-ALU with funct3=000, funct7b5=1: ALUControl=000.
- funct3=111: ALUControl=010.
REQ-032 op=1111111: TRAP after DECODE; illegal=1 and enables 0 for 20 cycles; rst_n pulse returns FETCH with illegal=0.
REQ-033 rst_n=0 mid-MEMWRITE: MemWrite drops before the next clock edge; state=0 after release.
